// File: rtl/elm_weight_loader.sv
// Streams per-neuron weight and bias words from an upstream valid/ready source
// into registered weight/bias strobes addressed to one ELM layer.
module elm_weight_loader #(
  parameter int dataWidth = 16,
  parameter int numWeight = 128,
  parameter int numNeuron = 32,
  parameter int layerNo   = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [dataWidth-1:0]   s_data,
  input  logic                   s_last,
  output logic                   weightValid,
  output logic [dataWidth-1:0]   weightValue,
  output logic [numNeuron-1:0]   biasValid,
  output logic [dataWidth-1:0]   biasValue,
  output logic [2*dataWidth:0]   config_layer_num,
  output logic [2*dataWidth:0]   config_neuron_num,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int unsigned WW = (numWeight > 1) ? $clog2(numWeight) : 1;
  localparam int unsigned NN = (numNeuron > 1) ? $clog2(numNeuron) : 1;
  localparam int unsigned CW = 2 * dataWidth + 1;
  localparam logic [WW-1:0] LAST_W = WW'(numWeight - 1);
  localparam logic [NN-1:0] LAST_N = NN'(numNeuron - 1);

  typedef enum logic [1:0] {IDLE, WEIGHT, BIAS, FINISH} state_t;

  state_t               r_state;
  state_t               w_next;
  logic [WW-1:0]        r_wcnt;
  logic [NN-1:0]        r_ncnt;
  logic                 w_accept;
  logic                 w_final;
  logic                 w_start;
  logic [numNeuron-1:0] w_bias_onehot;

  assign s_ready = (r_state == WEIGHT) || (r_state == BIAS);

  always_comb begin
    w_accept = s_valid && s_ready;
    w_final  = (r_state == BIAS) && (r_ncnt == LAST_N);
    // done is high only in the IDLE cycle right after FINISH; a start there is dropped
    w_start  = (r_state == IDLE) && start && !done;
    w_next   = r_state;
    case (r_state)
      IDLE:    if (w_start) w_next = WEIGHT;
      WEIGHT: begin
        if (w_accept) begin
          if (s_last)                 w_next = FINISH;
          else if (r_wcnt == LAST_W)  w_next = BIAS;
        end
      end
      BIAS: begin
        if (w_accept) begin
          if (w_final || s_last) w_next = FINISH;
          else                   w_next = WEIGHT;
        end
      end
      FINISH:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_bias_onehot = '0;
    for (int unsigned n = 0; n < numNeuron; n++) begin
      if (r_ncnt == NN'(n)) w_bias_onehot[n] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wcnt <= '0;
      r_ncnt <= '0;
    end else if (w_start) begin
      r_wcnt <= '0;
      r_ncnt <= '0;
    end else if (w_accept && (r_state == WEIGHT)) begin
      r_wcnt <= (r_wcnt == LAST_W) ? '0 : r_wcnt + 1'b1;
    end else if (w_accept && (r_state == BIAS)) begin
      r_ncnt <= w_final ? '0 : r_ncnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      weightValid       <= 1'b0;
      weightValue       <= '0;
      biasValid         <= '0;
      biasValue         <= '0;
      config_layer_num  <= '0;
      config_neuron_num <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
      err               <= 1'b0;
    end else begin
      weightValid <= 1'b0;
      biasValid   <= '0;
      done        <= (r_state == FINISH);
      if (w_start)                  busy <= 1'b1;
      else if (r_state == FINISH)   busy <= 1'b0;
      if (w_start)                                  err <= 1'b0;
      else if (w_accept && (s_last != w_final))     err <= 1'b1;
      if (w_accept) begin
        config_layer_num  <= CW'(layerNo);
        config_neuron_num <= CW'(r_ncnt);
        if (r_state == WEIGHT) begin
          weightValid <= 1'b1;
          weightValue <= s_data;
        end else begin
          biasValid <= w_bias_onehot;
          biasValue <= s_data;
        end
      end
    end
  end

endmodule
